fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets NUM_REQ independent producers share one synchronous FIFO write port.
- Each producer offers words with valid/ready handshaking.
- The arbiter grants one producer at a time for a burst of up to MAX_BURST words, then drives the FIFO's write_en/data_in and honours its full flag.
- Sits directly in front of the team's Sync_FIFO instance; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- DATA_WIDTH, 8, word width; equals the FIFO data_width.
- MAX_BURST, 4, maximum words per grant; 1..16.
- ID_W, 2, grant index width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i offers a word.
- req_data  in  NUM_REQ*DATA_WIDTH  word of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  bit i: current word of requester i ends its packet.
- req_ready  out  NUM_REQ  bit i: word of requester i accepted this cycle when valid.
- fifo_write_en  out  1  to FIFO write_en.
- fifo_data_in  out  DATA_WIDTH  to FIFO data_in.
- fifo_full  in  1  from FIFO full.
- grant_id  out  ID_W  index of the current grant holder; valid while busy=1.
- busy  out  1  a grant is active (BURST state).

Behaviour:
- Reset:
  - State IDLE; busy=0; grant_id=0; beat_cnt=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0; fifo_write_en=0; fifo_data_in=0.
  - A reset asserted mid-burst aborts the burst on the next edge. No write is issued in the reset cycle; fifo_write_en is forced to 0 combinationally while rst=1.
- States: IDLE and BURST.
- IDLE:
  - req_ready=0 and fifo_write_en=0.
  - If any req_valid is set, select the first set bit scanning from last_grant+1 upward, modulo NUM_REQ.
  - Register it into grant_id, clear beat_cnt, go to BURST.
  - Arbitration takes 1 cycle, so the first write occurs no earlier than the cycle after req_valid is seen in IDLE.
- BURST, with g = grant_id:
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - fifo_write_en = req_valid[g] & ~fifo_full.
  - fifo_data_in = req_data slice g (combinational mux). Hold the last written value when not writing; no X on the output.
  - Beat: a cycle with fifo_write_en=1. Each beat increments beat_cnt.
  - Exit to IDLE, with last_grant<=g, on the edge of a beat where req_last[g]=1 or beat_cnt==MAX_BURST-1.
  - Exit to IDLE, with last_grant<=g, if req_valid[g]=0 in a BURST cycle (requester stalled, grant released). This includes a drop on the first BURST cycle: that is a zero-beat grant, and priority still rotates.
  - fifo_full=1 stalls: no beat, no exit, grant held, beat_cnt unchanged.
- Outputs and timing:
  - busy=1 exactly in BURST.
  - grant_id holds its value through IDLE after a burst.
  - Back-to-back bursts have a 1-cycle IDLE gap; peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Arithmetic: beat_cnt is a $clog2(MAX_BURST)+1-bit counter and never exceeds MAX_BURST-1. The round-robin index wraps modulo NUM_REQ; NUM_REQ need not be a power of two.
- Simultaneous events:
  - req_last together with beat_cnt==MAX_BURST-1 gives a single exit.
  - req_last with fifo_full=1 is no beat, so no exit.
  - A requester deasserting valid while it does not hold the grant is ignored.
- Ordering: words from one requester reach the FIFO in order. Packets longer than MAX_BURST are split across grants and may be interleaved with other requesters' words.
- No writes are issued while fifo_full=1, so FIFO overflow is impossible by construction.

Test Plan:
- Reset, then req_valid=4'b0001, req_data0=8'hA0..A2, req_last on the 3rd word, fifo_full=0:
  - busy rises 1 cycle after valid.
  - 3 consecutive writes A0, A1, A2.
  - busy falls the next cycle; grant_id=0.
- All four requesters valid continuously, never last, MAX_BURST=4:
  - grants in order 0,1,2,3,0.
  - each grant gives exactly 4 writes.
  - 1 idle cycle between grants.
- Requester 2 mid-burst with fifo_full=1 for 3 cycles:
  - req_ready[2]=0 and fifo_write_en=0 for those cycles.
  - beat_cnt unchanged; grant held.
  - the remaining words write after full drops; no word is lost or duplicated.
- Requester 1 granted, then drops req_valid after 2 beats while requester 3 is valid:
  - return to IDLE.
  - next grant = 3; requester 1 next served only after the 2, 3, 0 scan.
- rst asserted for 1 cycle during the 2nd beat of a burst from requester 3:
  - that cycle has no write.
  - busy=0 next cycle.
  - requests 0 and 3 both pending afterwards: requester 0 is granted first.
- NUM_REQ=3 build, requesters 0 and 2 valid continuously:
  - grants alternate 0,2,0,2.
  - index never reaches 3.
  - the FIFO (depth 16) receives data in grant order with no overflow when the read side is held idle until full.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ valid/ready producers share one synchronous FIFO write port.
// Latency: 1 cycle of arbitration in IDLE, then up to MAX_BURST words at one word per cycle.
// Backpressure: fifo_full drops the grant holder's req_ready and stalls; grant and beat count are held.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int                CNT_W          = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT      = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   RST_LAST_GRANT = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]     NUM_REQ_W      = (ID_W+1)'(NUM_REQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_W-1:0]       grant_q;
    logic [ID_W-1:0]       grant_d;
    logic [ID_W-1:0]       last_grant_q;
    logic [ID_W-1:0]       last_grant_d;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic [CNT_W-1:0]      beat_cnt_d;
    logic [DATA_WIDTH-1:0] hold_q;

    // Round-robin pick and the grant holder's view of the request bus.
    logic [ID_W-1:0]       pick;
    logic                  pick_vld;
    logic [ID_W:0]         scan_idx;
    logic                  cur_vld;
    logic                  cur_last;
    logic [DATA_WIDTH-1:0] cur_dat;

    // Mux out the valid/last/data of the current grant holder.
    always_comb begin
        cur_vld  = 1'b0;
        cur_last = 1'b0;
        cur_dat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                cur_vld  = req_valid[i];
                cur_last = req_last[i];
                cur_dat  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scan from last_grant+1 upward modulo NUM_REQ; descending k so the nearest valid requester wins.
    always_comb begin
        pick     = last_grant_q;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (scan_idx == (ID_W+1)'(i) && req_valid[i]) begin
                    pick     = ID_W'(i);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    // State register: reset aborts any burst on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and arbitration bookkeeping; a beat is exactly a cycle with fifo_write_en high.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!cur_vld) begin
                    // Grant holder stalled: release, and rotate priority even after zero beats.
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                    beat_cnt_d   = '0;
                end else if (fifo_write_en) begin
                    if (cur_last || beat_cnt_q == LAST_BEAT) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: only the grant holder sees ready; writes are suppressed while full or in reset.
    always_comb begin
        req_ready     = '0;
        fifo_write_en = 1'b0;
        busy          = (state_q == ST_BURST);
        if (state_q == ST_BURST && !rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q == ID_W'(i)) begin
                    req_ready[i] = ~fifo_full;
                end
            end
            fifo_write_en = cur_vld & ~fifo_full;
        end
        fifo_data_in = fifo_write_en ? cur_dat : hold_q;
    end

    // Grant, priority pointer, beat counter and the held copy of the last written word.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= '0;
            last_grant_q <= RST_LAST_GRANT;
            beat_cnt_q   <= '0;
            hold_q       <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            if (fifo_write_en) begin
                hold_q <= cur_dat;
            end
        end
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues drive a 4-requester instance and a 3-requester instance
// feeding a depth-16 FIFO model; expected {grant_id, data} writes are queued by the stimulus and
// consumed by a negedge monitor.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_write_en;
    logic [DW-1:0]     fifo_data_in;
    logic              fifo_full;
    logic [IW-1:0]     grant_id;
    logic              busy;

    logic [2:0]        rv3;
    logic [3*DW-1:0]   rd3;
    logic [2:0]        rl3;
    logic [2:0]        rr3;
    logic              we3;
    logic [DW-1:0]     fd3;
    logic              full3;
    logic [IW-1:0]     gid3;
    logic              busy3;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_W(IW)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_W(IW)) u_dut3 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (rv3),
        .req_data      (rd3),
        .req_last      (rl3),
        .req_ready     (rr3),
        .fifo_write_en (we3),
        .fifo_data_in  (fd3),
        .fifo_full     (full3),
        .grant_id      (gid3),
        .busy          (busy3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]       pq [NR][$];
    logic [IW+DW-1:0] exp_q[$];
    logic [IW+DW-1:0] exp3_q[$];
    logic [IW+DW-1:0] e;
    logic [IW+DW-1:0] e3;
    logic [NR-1:0]    en;
    logic [NR-1:0]    hs = '0;
    logic [2:0]       hs3 = '0;
    logic             we3_s = 1'b0;
    logic             en3;
    logic [3:0]       c0;
    logic [3:0]       c2;
    int               fcnt;
    logic             nx_rst;
    logic             nx_full;

    function automatic logic [IW+DW-1:0] ev(input int id, input int d);
        return {IW'(id), DW'(d)};
    endfunction

    function automatic logic [8:0] pw(input logic l, input int d);
        return {l, 8'(d)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: sample handshakes and check every FIFO write against the scoreboard.
    always @(negedge clk) begin
        hs    = req_valid & req_ready;
        hs3   = rv3 & rr3;
        we3_s = we3;
        if (fifo_write_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %0h:%0h with nothing expected", grant_id, fifo_data_in);
            end else begin
                e = exp_q.pop_front();
                chk("write", {22'd0, grant_id, fifo_data_in}, {22'd0, e});
            end
        end
        if (fifo_full) chk("no_write_while_full", {31'd0, fifo_write_en}, 32'd0);
        if (we3) begin
            if (exp3_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write3: got %0h:%0h with nothing expected", gid3, fd3);
            end else begin
                e3 = exp3_q.pop_front();
                chk("write3", {22'd0, gid3, fd3}, {22'd0, e3});
            end
        end
        if (full3) chk("no_write3_while_full", {31'd0, we3}, 32'd0);
        if (busy3) chk("grant3_below_3", {31'd0, (gid3 == 2'd3)}, 32'd0);
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (en[i] && pq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pq[i][0][7:0];
                req_last[i]           = pq[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
        rv3   = {en3, 1'b0, en3};
        rd3   = {4'h2, c2, 8'h00, 4'h0, c0};
        rl3   = '0;
        full3 = (fcnt >= 16);
    endtask

    // Advance one clock: consume accepted words, apply pending rst/full, drive, then wait to mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        if (hs3[0]) c0 = c0 + 4'd1;
        if (hs3[2]) c2 = c2 + 4'd1;
        if (we3_s) fcnt++;
        rst       = nx_rst;
        fifo_full = nx_full;
        drive();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; nx_rst = 1'b1; fifo_full = 1'b0; nx_full = 1'b0;
        en = '0; en3 = 1'b0; c0 = '0; c2 = '0; fcnt = 0;
        req_valid = '0; req_data = '0; req_last = '0;
        rv3 = '0; rd3 = '0; rl3 = '0; full3 = 1'b0;
        step(); step();

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, fifo_write_en}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_data", {24'd0, fifo_data_in}, 32'd0);
        chk("rst_busy3", {31'd0, busy3}, 32'd0);

        // Single 3-word packet from requester 0
        nx_rst = 1'b0;
        pq[0].push_back(pw(0, 'hA0)); pq[0].push_back(pw(0, 'hA1)); pq[0].push_back(pw(1, 'hA2));
        exp_q.push_back(ev(0, 'hA0)); exp_q.push_back(ev(0, 'hA1)); exp_q.push_back(ev(0, 'hA2));
        en = 4'b0001;
        step();
        chk("t1_busy_c0", {31'd0, busy}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("t1_busy", {31'd0, busy}, 32'd1);
            chk("t1_we", {31'd0, fifo_write_en}, 32'd1);
        end
        step();
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_grant_end", {30'd0, grant_id}, 32'd0);
        chk("t1_drained", exp_q.size(), 32'd0);

        // All four requesters continuously valid, never last
        nx_rst = 1'b1; en = '0;
        step();
        nx_rst = 1'b0;
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 8; k++) pq[i].push_back(pw(0, i*16 + k));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++)
                for (int k = 0; k < 4; k++) exp_q.push_back(ev(i, i*16 + r*4 + k));
        en = 4'b1111;
        step();
        for (int c = 0; c < 40; c++) begin
            chk("t2_busy", {31'd0, busy}, {31'd0, (c % 5 != 0)});
            if (c % 5 != 0) begin
                chk("t2_grant", {30'd0, grant_id}, (c / 5) % 4);
                chk("t2_we", {31'd0, fifo_write_en}, 32'd1);
            end
            step();
        end
        chk("t2_busy_end", {31'd0, busy}, 32'd0);
        chk("t2_drained", exp_q.size(), 32'd0);

        // Requester 2 stalled by fifo_full for 3 cycles mid-burst
        en = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            pq[2].push_back(pw(0, 'hC0 + k));
            exp_q.push_back(ev(2, 'hC0 + k));
        end
        step();
        chk("t3_busy_c0", {31'd0, busy}, 32'd0);
        step();
        chk("t3_we_c1", {31'd0, fifo_write_en}, 32'd1);
        step();
        chk("t3_we_c2", {31'd0, fifo_write_en}, 32'd1);
        nx_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_ready_full", {28'd0, req_ready}, 32'd0);
            chk("t3_we_full", {31'd0, fifo_write_en}, 32'd0);
            chk("t3_busy_full", {31'd0, busy}, 32'd1);
            chk("t3_grant_full", {30'd0, grant_id}, 32'd2);
        end
        nx_full = 1'b0;
        step();
        chk("t3_we_c6", {31'd0, fifo_write_en}, 32'd1);
        step();
        chk("t3_busy_c7", {31'd0, busy}, 32'd1);
        step();
        chk("t3_busy_c8", {31'd0, busy}, 32'd0);
        chk("t3_drained", exp_q.size(), 32'd0);

        // Requester 1 drops valid after 2 beats while requester 3 waits
        nx_rst = 1'b1; en = '0;
        step();
        nx_rst = 1'b0;
        pq[1].push_back(pw(0, 'h10)); pq[1].push_back(pw(0, 'h11)); pq[1].push_back(pw(1, 'h12));
        pq[3].push_back(pw(0, 'h30)); pq[3].push_back(pw(1, 'h31));
        exp_q.push_back(ev(1, 'h10)); exp_q.push_back(ev(1, 'h11));
        exp_q.push_back(ev(3, 'h30)); exp_q.push_back(ev(3, 'h31)); exp_q.push_back(ev(1, 'h12));
        en = 4'b1010;
        step();
        step();
        chk("t4_grant_c1", {30'd0, grant_id}, 32'd1);
        step();
        en = 4'b1000;
        step();
        chk("t4_busy_drop", {31'd0, busy}, 32'd1);
        chk("t4_we_drop", {31'd0, fifo_write_en}, 32'd0);
        en = 4'b1010;
        step();
        chk("t4_busy_idle", {31'd0, busy}, 32'd0);
        step();
        chk("t4_grant_next", {30'd0, grant_id}, 32'd3);
        chk("t4_we_next", {31'd0, fifo_write_en}, 32'd1);
        step();
        step();
        chk("t4_busy_c7", {31'd0, busy}, 32'd0);
        step();
        chk("t4_grant_c8", {30'd0, grant_id}, 32'd1);
        step();
        chk("t4_busy_c9", {31'd0, busy}, 32'd0);
        chk("t4_drained", exp_q.size(), 32'd0);

        // Reset during the 2nd beat of a requester-3 burst
        en = 4'b1000;
        pq[3].push_back(pw(0, 'h38)); pq[3].push_back(pw(0, 'h39));
        pq[3].push_back(pw(0, 'h3A)); pq[3].push_back(pw(1, 'h3B));
        exp_q.push_back(ev(3, 'h38));
        step();
        step();
        chk("t5_we_c1", {31'd0, fifo_write_en}, 32'd1);
        chk("t5_grant_c1", {30'd0, grant_id}, 32'd3);
        nx_rst = 1'b1;
        step();
        chk("t5_we_rst", {31'd0, fifo_write_en}, 32'd0);
        chk("t5_ready_rst", {28'd0, req_ready}, 32'd0);
        nx_rst = 1'b0;
        pq[0].push_back(pw(1, 'h05));
        exp_q.push_back(ev(0, 'h05)); exp_q.push_back(ev(3, 'h39));
        exp_q.push_back(ev(3, 'h3A)); exp_q.push_back(ev(3, 'h3B));
        en = 4'b1001;
        step();
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        step();
        chk("t5_grant_first", {30'd0, grant_id}, 32'd0);
        step();
        step();
        chk("t5_grant_second", {30'd0, grant_id}, 32'd3);
        step(); step(); step();
        chk("t5_busy_end", {31'd0, busy}, 32'd0);
        chk("t5_drained", exp_q.size(), 32'd0);

        // 3-requester build, requesters 0 and 2 valid, FIFO read side idle until full
        en = '0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp3_q.push_back(ev(0, r*4 + k));
            for (int k = 0; k < 4; k++) exp3_q.push_back(ev(2, 'h20 + r*4 + k));
        end
        en3 = 1'b1;
        for (int c = 0; c < 40; c++) step();
        chk("t6_fifo_count", fcnt, 32'd16);
        chk("t6_drained", exp3_q.size(), 32'd0);
        chk("t6_stalled_busy", {31'd0, busy3}, 32'd1);
        chk("t6_stalled_we", {31'd0, we3}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
